// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        RESET,
        HOLD,
        RELEASE,
        RUN,
        SWHOLD,
        SWACK
    } seq_state_t;

    function automatic int counter_width(input int hold_cycles, input int stage_gap);
        int longest;
        longest = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously with rst_n, deasserts after SYNC_STAGES clocks.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = stages[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes the board reset, holds every domain, then releases
// domains one by one; software can re-run the sequence through a req/ack handshake.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_GAP   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic                   sync_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   all_released
);

    localparam int CNT_W = counter_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_RESET = '1;

    seq_state_t             state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [IDX_W-1:0]       idx, idx_next;
    logic [NUM_DOMAINS-1:0] rst_out_next;
    logic                   all_released_next;
    logic                   sw_rst_ack_next;
    logic                   first_release;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_rst(sync_rst)
    );

    // sync_rst follows rst_n with zero delay on assertion, so every output here
    // drops back to its reset value asynchronously as well.
    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) begin
            state        <= RESET;
            cnt          <= '0;
            idx          <= '0;
            rst_out      <= ALL_RESET;
            all_released <= 1'b0;
            sw_rst_ack   <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            rst_out      <= rst_out_next;
            all_released <= all_released_next;
            sw_rst_ack   <= sw_rst_ack_next;
        end
    end

    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        idx_next          = idx;
        rst_out_next      = rst_out;
        all_released_next = all_released;
        sw_rst_ack_next   = sw_rst_ack;
        first_release     = 1'b0;

        case (state)
            RESET: begin
                state_next = HOLD;
                cnt_next   = '0;
            end
            HOLD, SWHOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_next = '0;
                    if (state == HOLD) begin
                        first_release = 1'b1;
                    end else begin
                        state_next      = SWACK;
                        sw_rst_ack_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SWACK: begin
                if (!sw_rst_req) begin
                    sw_rst_ack_next = 1'b0;
                    first_release   = 1'b1;
                end
            end
            RELEASE: begin
                if (cnt == GAP_LAST) begin
                    cnt_next          = '0;
                    rst_out_next[idx] = 1'b0;
                    idx_next          = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_next        = RUN;
                        all_released_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                if (sw_rst_req) begin
                    state_next        = SWHOLD;
                    cnt_next          = '0;
                    rst_out_next      = ALL_RESET;
                    all_released_next = 1'b0;
                end
            end
            default: begin
                state_next = RESET;
            end
        endcase

        // Domain 0 always leaves reset on the edge that ends a hold or handshake.
        if (first_release) begin
            rst_out_next = ALL_RESET << 1;
            cnt_next     = '0;
            idx_next     = IDX_W'(1);
            if (NUM_DOMAINS == 1) begin
                state_next        = RUN;
                all_released_next = 1'b1;
            end else begin
                state_next = RELEASE;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal one-domain instance.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic       sync_rst;
    logic [3:0] rst_out;
    logic       all_released;

    logic       sw_rst_ack_b;
    logic       sync_rst_b;
    logic [0:0] rst_out_b;
    logic       all_released_b;

    int edge_num;
    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .NUM_DOMAINS(4),
        .STAGE_GAP  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (sw_rst_req),
        .sw_rst_ack  (sw_rst_ack),
        .sync_rst    (sync_rst),
        .rst_out     (rst_out),
        .all_released(all_released)
    );

    reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(1),
        .NUM_DOMAINS(1),
        .STAGE_GAP  (1)
    ) dut_min (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (1'b0),
        .sw_rst_ack  (sw_rst_ack_b),
        .sync_rst    (sync_rst_b),
        .rst_out     (rst_out_b),
        .all_released(all_released_b)
    );

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s (edge %0d): got %0h, expected %0h",
                     tag, edge_num, actual, expected);
        end
    endtask

    // Edges are counted from the most recent falling edge of rst_n.
    task automatic advance_to(input int target);
        while (edge_num < target) begin
            @(posedge clk);
            edge_num++;
        end
        #1;
    endtask

    task automatic release_board_reset();
        rst_n    = 1'b0;
        edge_num = 0;
    endtask

    initial begin
        rst_n      = 1'b1;
        sw_rst_req = 1'b0;
        edge_num   = 0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset rst_out", 32'(rst_out), 32'hF);
        check_output("reset sync_rst", 32'(sync_rst), 32'h1);
        check_output("reset all_released", 32'(all_released), 32'h0);
        check_output("reset sw_rst_ack", 32'(sw_rst_ack), 32'h0);
        check_output("reset min rst_out", 32'(rst_out_b), 32'h1);

        // Power-up sequence.
        release_board_reset();
        advance_to(1);
        check_output("sync_rst edge1", 32'(sync_rst), 32'h1);
        advance_to(2);
        check_output("sync_rst edge2", 32'(sync_rst), 32'h0);
        check_output("rst_out edge2", 32'(rst_out), 32'hF);
        advance_to(3);
        check_output("min rst_out edge3", 32'(rst_out_b), 32'h1);
        check_output("min all_released edge3", 32'(all_released_b), 32'h0);
        advance_to(4);
        check_output("min rst_out edge4", 32'(rst_out_b), 32'h0);
        check_output("min all_released edge4", 32'(all_released_b), 32'h1);
        advance_to(18);
        check_output("rst_out edge18", 32'(rst_out), 32'hF);
        advance_to(19);
        check_output("rst_out edge19", 32'(rst_out), 32'hE);
        advance_to(22);
        check_output("rst_out edge22", 32'(rst_out), 32'hE);
        advance_to(23);
        check_output("rst_out edge23", 32'(rst_out), 32'hC);
        advance_to(27);
        check_output("rst_out edge27", 32'(rst_out), 32'h8);
        advance_to(30);
        check_output("all_released edge30", 32'(all_released), 32'h0);
        advance_to(31);
        check_output("rst_out edge31", 32'(rst_out), 32'h0);
        check_output("all_released edge31", 32'(all_released), 32'h1);

        // Software reset requested at edge 32, dropped so it is first seen low at 52.
        sw_rst_req = 1'b1;
        advance_to(32);
        check_output("sw rst_out N", 32'(rst_out), 32'hF);
        check_output("sw all_released N", 32'(all_released), 32'h0);
        check_output("sw ack N", 32'(sw_rst_ack), 32'h0);
        advance_to(47);
        check_output("sw ack N+15", 32'(sw_rst_ack), 32'h0);
        advance_to(48);
        check_output("sw ack N+16", 32'(sw_rst_ack), 32'h1);
        check_output("sw rst_out N+16", 32'(rst_out), 32'hF);
        advance_to(51);
        check_output("sw ack held", 32'(sw_rst_ack), 32'h1);
        sw_rst_req = 1'b0;
        advance_to(52);
        check_output("sw ack M", 32'(sw_rst_ack), 32'h0);
        check_output("sw rst_out M", 32'(rst_out), 32'hE);
        check_output("sw all_released M", 32'(all_released), 32'h0);
        advance_to(56);
        check_output("sw rst_out M+4", 32'(rst_out), 32'hC);
        advance_to(63);
        check_output("sw rst_out M+11", 32'(rst_out), 32'h8);
        check_output("sw all_released M+11", 32'(all_released), 32'h0);
        advance_to(64);
        check_output("sw rst_out M+12", 32'(rst_out), 32'h0);
        check_output("sw all_released M+12", 32'(all_released), 32'h1);

        // Board reset from RUN must drop all_released without a clock edge.
        rst_n = 1'b1;
        #1;
        check_output("async run all_released", 32'(all_released), 32'h0);
        check_output("async run rst_out", 32'(rst_out), 32'hF);
        check_output("async run sync_rst", 32'(sync_rst), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        release_board_reset();
        advance_to(19);
        check_output("pulse rst_out edge19", 32'(rst_out), 32'hE);
        advance_to(24);
        check_output("pulse rst_out edge24", 32'(rst_out), 32'hC);
        #2;
        rst_n = 1'b1;
        #1;
        check_output("pulse rst_out async", 32'(rst_out), 32'hF);
        check_output("pulse all_released async", 32'(all_released), 32'h0);
        #1;
        release_board_reset();
        advance_to(2);
        check_output("restart sync_rst edge2", 32'(sync_rst), 32'h0);
        advance_to(18);
        check_output("restart rst_out edge18", 32'(rst_out), 32'hF);
        advance_to(19);
        check_output("restart rst_out edge19", 32'(rst_out), 32'hE);
        advance_to(31);
        check_output("restart rst_out edge31", 32'(rst_out), 32'h0);
        check_output("restart all_released edge31", 32'(all_released), 32'h1);

        // Request raised during RELEASE is deferred until RUN.
        rst_n = 1'b1;
        #1;
        check_output("seq3 rst_out async", 32'(rst_out), 32'hF);
        repeat (2) @(posedge clk);
        #1;
        release_board_reset();
        advance_to(19);
        sw_rst_req = 1'b1;
        advance_to(30);
        check_output("early req rst_out edge30", 32'(rst_out), 32'h8);
        advance_to(31);
        check_output("early req rst_out edge31", 32'(rst_out), 32'h0);
        check_output("early req all_released edge31", 32'(all_released), 32'h1);
        advance_to(32);
        check_output("early req rst_out edge32", 32'(rst_out), 32'hF);
        check_output("early req all_released edge32", 32'(all_released), 32'h0);
        advance_to(47);
        check_output("early req ack edge47", 32'(sw_rst_ack), 32'h0);
        advance_to(48);
        check_output("early req ack edge48", 32'(sw_rst_ack), 32'h1);

        // Board reset during SWACK.
        advance_to(49);
        rst_n = 1'b1;
        #1;
        check_output("swack async ack", 32'(sw_rst_ack), 32'h0);
        check_output("swack async rst_out", 32'(rst_out), 32'hF);
        check_output("swack async sync_rst", 32'(sync_rst), 32'h1);
        sw_rst_req = 1'b0;
        release_board_reset();
        advance_to(1);
        check_output("post swack sync_rst edge1", 32'(sync_rst), 32'h1);
        check_output("post swack rst_out edge1", 32'(rst_out), 32'hF);
        advance_to(2);
        check_output("post swack sync_rst edge2", 32'(sync_rst), 32'h0);
        advance_to(18);
        check_output("post swack rst_out edge18", 32'(rst_out), 32'hF);
        advance_to(19);
        check_output("post swack rst_out edge19", 32'(rst_out), 32'hE);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
